// File: rtl/usr_seq_ctrl_if.sv
// Command handshake between the bus-side command source and the USR sequencer.
interface usr_seq_ctrl_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [WIDTH-1:0] cmd_data;

  modport master (
    output cmd_valid, cmd_op, cmd_cnt, cmd_data,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_cnt, cmd_data,
    output cmd_ready
  );
endinterface

// File: rtl/usr_seq_ctrl.sv
// Sequencer driving a universal shift register from load/shift/clear commands,
// keeping a shadow copy that is fed back as the load value to emulate hold.
module usr_seq_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             clr,
  usr_seq_ctrl_if.slave    cmd,
  output logic [1:0]       usr_sel,
  output logic             usr_shift_en,
  output logic [WIDTH-1:0] usr_data,
  output logic             usr_clr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] shadow
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_SHR   = 2'b01,
    OP_SHL   = 2'b10,
    OP_CLEAR = 2'b11
  } op_t;

  localparam logic [CNT_W-1:0] STEP_ONE = CNT_W'(1);

  state_t           state;
  op_t              op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] step;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state  <= IDLE;
      shadow <= '0;
      step   <= '0;
      op_q   <= OP_LOAD;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd.cmd_valid) begin
            op_q   <= op_t'(cmd.cmd_op);
            cnt_q  <= cmd.cmd_cnt;
            data_q <= cmd.cmd_data;
            step   <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          case (op_q)
            OP_LOAD: begin
              shadow <= data_q;
              state  <= FIN;
            end
            OP_CLEAR: begin
              shadow <= '0;
              state  <= FIN;
            end
            default: begin
              if (cnt_q == '0) begin
                state <= FIN;
              end else begin
                if (op_q == OP_SHR) begin
                  shadow <= {1'b0, shadow[WIDTH-1:1]};
                end else begin
                  shadow <= {shadow[WIDTH-2:0], data_q[WIDTH-1]};
                  // Rotating the latched word keeps the next serial bit at the MSB,
                  // giving data[(WIDTH-1-k) mod WIDTH] on step k without an index.
                  data_q <= {data_q[WIDTH-2:0], data_q[WIDTH-1]};
                end
                step <= step + STEP_ONE;
                if (step == cnt_q - STEP_ONE) state <= FIN;
              end
            end
          endcase
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    usr_sel      = 2'b00;
    usr_shift_en = 1'b0;
    usr_data     = shadow;
    usr_clr      = clr;
    if (state == RUN) begin
      case (op_q)
        OP_LOAD:  usr_data = data_q;
        OP_CLEAR: usr_clr  = 1'b1;
        OP_SHR: begin
          if (cnt_q != '0) begin
            usr_shift_en = 1'b1;
            usr_data     = '0;
          end
        end
        OP_SHL: begin
          if (cnt_q != '0) begin
            usr_sel      = 2'b10;
            usr_shift_en = 1'b1;
            usr_data     = {{(WIDTH-1){1'b0}}, data_q[WIDTH-1]};
          end
        end
        default: ;
      endcase
    end
  end

  assign cmd.cmd_ready = (state == IDLE) && !clr;
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);

endmodule

// File: tb/tb_usr_seq_ctrl.sv
// Directed bench for usr_seq_ctrl with a behavioural USR fed by the DUT outputs.
module tb_usr_seq_ctrl;

  logic       clk;
  logic       clr;
  logic [1:0] usr_sel;
  logic       usr_shift_en;
  logic [3:0] usr_data;
  logic       usr_clr;
  logic       busy;
  logic       done;
  logic [3:0] shadow;
  logic [3:0] usr_q;
  int         tests;
  int         fails;

  usr_seq_ctrl_if #(.WIDTH(4), .CNT_W(3)) cmd ();

  usr_seq_ctrl #(.WIDTH(4), .CNT_W(3)) dut (
    .clk          (clk),
    .clr          (clr),
    .cmd          (cmd),
    .usr_sel      (usr_sel),
    .usr_shift_en (usr_shift_en),
    .usr_data     (usr_data),
    .usr_clr      (usr_clr),
    .busy         (busy),
    .done         (done),
    .shadow       (shadow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference USR using the documented sel/shift_en encoding.
  always_ff @(posedge clk or posedge clr) begin
    if (clr)                                  usr_q <= '0;
    else if (usr_clr)                         usr_q <= '0;
    else if (usr_sel == 2'b10 && usr_shift_en) usr_q <= {usr_q[2:0], usr_data[0]};
    else if (usr_shift_en)                    usr_q <= {1'b0, usr_q[3:1]};
    else                                      usr_q <= usr_data;
  end

  task automatic send(input logic [1:0] op, input logic [2:0] cnt, input logic [3:0] data);
    int unsigned w;
    w = 0;
    while (!cmd.cmd_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    tests++;
    if (cmd.cmd_ready !== 1'b1) begin
      $display("FAIL send_ready got %b exp 1", cmd.cmd_ready);
      fails++;
    end
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op    = op;
    cmd.cmd_cnt   = cnt;
    cmd.cmd_data  = data;
    @(posedge clk); #1;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = ~op;
    cmd.cmd_cnt   = ~cnt;
    cmd.cmd_data  = ~data;
  endtask

  task automatic test_reset;
    clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    clr = 1'b1;
    #1;
    tests++;
    if ({usr_clr, shadow, busy, done, cmd.cmd_ready} !== {1'b1, 4'b0000, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_async got clr=%b sh=%b busy=%b done=%b rdy=%b exp 1 0000 0 0 0",
               usr_clr, shadow, busy, done, cmd.cmd_ready);
      fails++;
    end
    tests++;
    if ({usr_sel, usr_shift_en, usr_data} !== 7'b0) begin
      $display("FAIL reset_usr got sel=%b en=%b data=%b exp 00 0 0000", usr_sel, usr_shift_en, usr_data);
      fails++;
    end
    @(negedge clk) clr = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({cmd.cmd_ready, usr_clr} !== 2'b10) begin
      $display("FAIL reset_release got rdy=%b clr=%b exp 1 0", cmd.cmd_ready, usr_clr);
      fails++;
    end
  endtask

  task automatic test_load;
    send(2'b00, 3'd5, 4'b1011);
    tests++;
    if ({usr_sel, usr_shift_en, usr_data, busy, cmd.cmd_ready} !== {2'b00, 1'b0, 4'b1011, 1'b1, 1'b0}) begin
      $display("FAIL load_run got sel=%b en=%b data=%b busy=%b rdy=%b exp 00 0 1011 1 0",
               usr_sel, usr_shift_en, usr_data, busy, cmd.cmd_ready);
      fails++;
    end
    @(posedge clk); #1;
    tests++;
    if ({done, shadow, usr_q} !== {1'b1, 4'b1011, 4'b1011}) begin
      $display("FAIL load_fin got done=%b sh=%b usr=%b exp 1 1011 1011", done, shadow, usr_q);
      fails++;
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if ({done, cmd.cmd_ready, usr_data, usr_q} !== {1'b0, 1'b1, 4'b1011, 4'b1011}) begin
      $display("FAIL load_hold got done=%b rdy=%b data=%b usr=%b exp 0 1 1011 1011",
               done, cmd.cmd_ready, usr_data, usr_q);
      fails++;
    end
  endtask

  task automatic test_shr;
    logic [3:0] exp_sh [2];
    exp_sh[0] = 4'b0101;
    exp_sh[1] = 4'b0010;
    send(2'b01, 3'd2, 4'b1111);
    for (int k = 0; k < 2; k++) begin
      tests++;
      if ({usr_sel, usr_shift_en, done} !== 4'b0010) begin
        $display("FAIL shr_drive step %0d got sel=%b en=%b done=%b exp 00 1 0", k, usr_sel, usr_shift_en, done);
        fails++;
      end
      @(posedge clk); #1;
      tests++;
      if ({shadow, usr_q} !== {exp_sh[k], exp_sh[k]}) begin
        $display("FAIL shr_shadow step %0d got sh=%b usr=%b exp %b", k, shadow, usr_q, exp_sh[k]);
        fails++;
      end
    end
    tests++;
    if (done !== 1'b1) begin
      $display("FAIL shr_done got %b exp 1", done);
      fails++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_clear_shl;
    logic [3:0] exp_sh [4];
    logic       exp_bit [4];
    exp_sh[0] = 4'b0001; exp_sh[1] = 4'b0011; exp_sh[2] = 4'b0110; exp_sh[3] = 4'b1100;
    exp_bit[0] = 1'b1; exp_bit[1] = 1'b1; exp_bit[2] = 1'b0; exp_bit[3] = 1'b0;
    send(2'b11, 3'd3, 4'b1010);
    tests++;
    if ({usr_clr, usr_shift_en} !== 2'b10) begin
      $display("FAIL clear_run got clr=%b en=%b exp 1 0", usr_clr, usr_shift_en);
      fails++;
    end
    @(posedge clk); #1;
    tests++;
    if ({done, usr_clr, shadow, usr_q} !== {1'b1, 1'b0, 4'b0000, 4'b0000}) begin
      $display("FAIL clear_fin got done=%b clr=%b sh=%b usr=%b exp 1 0 0000 0000", done, usr_clr, shadow, usr_q);
      fails++;
    end
    @(posedge clk); #1;
    send(2'b10, 3'd4, 4'b1100);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if ({usr_sel, usr_shift_en, usr_data} !== {2'b10, 1'b1, 3'b000, exp_bit[k]}) begin
        $display("FAIL shl_drive step %0d got sel=%b en=%b data=%b exp 10 1 000%b",
                 k, usr_sel, usr_shift_en, usr_data, exp_bit[k]);
        fails++;
      end
      @(posedge clk); #1;
      tests++;
      if ({shadow, usr_q} !== {exp_sh[k], exp_sh[k]}) begin
        $display("FAIL shl_shadow step %0d got sh=%b usr=%b exp %b", k, shadow, usr_q, exp_sh[k]);
        fails++;
      end
    end
    tests++;
    if (done !== 1'b1) begin
      $display("FAIL shl_done got %b exp 1", done);
      fails++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_shr_zero;
    send(2'b01, 3'd0, 4'b0110);
    tests++;
    if ({usr_shift_en, usr_sel, usr_data, busy} !== {1'b0, 2'b00, 4'b1100, 1'b1}) begin
      $display("FAIL shr0_run got en=%b sel=%b data=%b busy=%b exp 0 00 1100 1",
               usr_shift_en, usr_sel, usr_data, busy);
      fails++;
    end
    @(posedge clk); #1;
    tests++;
    if ({done, usr_shift_en, shadow, usr_q} !== {1'b1, 1'b0, 4'b1100, 4'b1100}) begin
      $display("FAIL shr0_fin got done=%b en=%b sh=%b usr=%b exp 1 0 1100 1100", done, usr_shift_en, shadow, usr_q);
      fails++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_shl_max;
    int n;
    n = 0;
    send(2'b10, 3'd7, 4'b1010);
    while (!done && n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if (n !== 7) begin
      $display("FAIL shl7_latency got %0d exp 7", n);
      fails++;
    end
    tests++;
    if ({shadow, usr_q} !== 8'b0101_0101) begin
      $display("FAIL shl7_shadow got sh=%b usr=%b exp 0101", shadow, usr_q);
      fails++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [1:0] ops   [4];
    logic [2:0] cnts  [4];
    logic [3:0] datas [4];
    int         n_acc;
    int         n_done;
    logic       acc;
    ops[0] = 2'b00; cnts[0] = 3'd0; datas[0] = 4'b0110;
    ops[1] = 2'b01; cnts[1] = 3'd1; datas[1] = 4'b1111;
    ops[2] = 2'b00; cnts[2] = 3'd0; datas[2] = 4'b1001;
    ops[3] = 2'b11; cnts[3] = 3'd0; datas[3] = 4'b1111;
    n_acc = 0;
    n_done = 0;
    cmd.cmd_valid = 1'b1;
    cmd.cmd_op = ops[0]; cmd.cmd_cnt = cnts[0]; cmd.cmd_data = datas[0];
    for (int c = 0; c < 40 && n_acc < 4; c++) begin
      acc = cmd.cmd_ready;
      @(posedge clk); #1;
      if (done) n_done++;
      if (acc) begin
        n_acc++;
        if (n_acc < 4) begin
          cmd.cmd_op = ops[n_acc]; cmd.cmd_cnt = cnts[n_acc]; cmd.cmd_data = datas[n_acc];
        end
      end
    end
    cmd.cmd_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    tests++;
    if (n_acc !== 4 || n_done !== 4) begin
      $display("FAIL b2b_count got acc=%0d done=%0d exp 4 4", n_acc, n_done);
      fails++;
    end
    tests++;
    if ({shadow, usr_q, cmd.cmd_ready} !== {4'b0000, 4'b0000, 1'b1}) begin
      $display("FAIL b2b_final got sh=%b usr=%b rdy=%b exp 0000 0000 1", shadow, usr_q, cmd.cmd_ready);
      fails++;
    end
  endtask

  task automatic test_reset_mid;
    int n_done;
    n_done = 0;
    send(2'b10, 3'd4, 4'b1111);
    @(posedge clk); #1;
    @(posedge clk); #1;
    tests++;
    if (shadow !== 4'b0011) begin
      $display("FAIL midrst_pre got %b exp 0011", shadow);
      fails++;
    end
    #2 clr = 1'b1;
    #1;
    tests++;
    if ({shadow, busy, done, usr_clr, usr_q} !== {4'b0000, 1'b0, 1'b0, 1'b1, 4'b0000}) begin
      $display("FAIL midrst_abort got sh=%b busy=%b done=%b clr=%b usr=%b exp 0000 0 0 1 0000",
               shadow, busy, done, usr_clr, usr_q);
      fails++;
    end
    @(posedge clk);
    @(negedge clk) clr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    tests++;
    if (n_done !== 0) begin
      $display("FAIL midrst_nodone got %0d exp 0", n_done);
      fails++;
    end
    send(2'b00, 3'd0, 4'b0101);
    @(posedge clk); #1;
    tests++;
    if ({done, shadow, usr_q} !== {1'b1, 4'b0101, 4'b0101}) begin
      $display("FAIL midrst_after got done=%b sh=%b usr=%b exp 1 0101 0101", done, shadow, usr_q);
      fails++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    cmd.cmd_valid = 1'b0;
    cmd.cmd_op    = 2'b00;
    cmd.cmd_cnt   = 3'd0;
    cmd.cmd_data  = 4'b0000;
    test_reset();
    test_load();
    test_shr();
    test_clear_shl();
    test_shr_zero();
    test_shl_max();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

endmodule
